// File: rtl/dm_sized.sv
`default_nettype none
// ============================================================================
// Module   : dm_sized
// Purpose  : Parametrised single-port data memory with byte/half/word stores
//            (byte-lane enables), sign/zero-extending loads, registered read
//            data with a valid strobe, and a post-reset clear sweep that
//            zeroes every word over DEPTH cycles.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req, we             - access request, 1 = store / 0 = load
//            size, uext          - 00 byte, 01 half, 10 word, 11 reserved;
//                                  zero-extend loads when uext = 1
//            addr, wdata         - byte address, right-aligned store data
//            rdata, rvalid       - registered load data and its strobe
//            busy                - clear sweep running, requests ignored
//            err                 - misalignment / reserved-size strobe
// Options  : DM_MISALIGN_CHK_EN  - when defined, misaligned halves/words and
//                                  size = 11 raise err, suppress stores and
//                                  return 0 for loads; when undefined err is
//                                  tied low and low address bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dm_sized #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);

    localparam int c_IDX_W = ADDR_W - 2;
    localparam int c_DEPTH = 1 << c_IDX_W;

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    // The lane logic below is written for four 8-bit lanes only.
    generate
        if (DATA_W != 32) begin : g_data_w_check
            $error("dm_sized: DATA_W must be 32");
        end
    endgenerate

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] w_cnt_nxt;

    logic [31:0]        r_mem [0:c_DEPTH-1];

    logic               w_acc;
    logic               w_misalign;
    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_st_be;
    logic [31:0]        w_st_data;

    logic               w_mem_we;
    logic [c_IDX_W-1:0] w_mem_idx;
    logic [3:0]         w_mem_be;
    logic [31:0]        w_mem_data;

    logic [31:0]        w_rd_word;
    logic [7:0]         w_rd_byte;
    logic [15:0]        w_rd_half;
    logic [31:0]        w_load_val;

    logic [31:0]        r_rdata;
    logic               r_rvalid;

    // ------------------------------------------------------------------
    // Sweep / idle state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // Last word is cleared on this edge; serve requests next.
                if (r_cnt == {c_IDX_W{1'b1}}) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign busy  = (r_state == c_ST_CLEAR);
    assign w_acc = req & ~busy;
    assign w_idx = addr[ADDR_W-1:2];

    // ------------------------------------------------------------------
    // Alignment check
    // ------------------------------------------------------------------
`ifdef DM_MISALIGN_CHK_EN
    assign w_misalign = ((size == 2'b01) & addr[0])
                      | ((size == 2'b10) & (addr[1:0] != 2'b00))
                      |  (size == 2'b11);
`else
    assign w_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Store lane selection: data is replicated across lanes so the byte
    // enables alone pick where it lands.
    // ------------------------------------------------------------------
    always_comb begin
        w_st_be   = 4'hF;
        w_st_data = wdata;
        case (size)
            2'b00: begin
                w_st_be   = 4'b0001 << addr[1:0];
                w_st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_st_be   = addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{wdata[15:0]}};
            end
            default: begin
                w_st_be   = 4'hF;
                w_st_data = wdata;
            end
        endcase
    end

    // Single write port shared by the clear sweep and stores.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_idx  = w_idx;
        w_mem_be   = w_st_be;
        w_mem_data = w_st_data;
        if (busy) begin
            w_mem_we   = 1'b1;
            w_mem_idx  = r_cnt;
            w_mem_be   = 4'hF;
            w_mem_data = '0;
        end else begin
            w_mem_we   = w_acc & we & ~w_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_mem_be[k]) begin
                    r_mem[w_mem_idx][8*k +: 8] <= w_mem_data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_rd_byte = w_rd_word[7:0];
        case (addr[1:0])
            2'b00:   w_rd_byte = w_rd_word[7:0];
            2'b01:   w_rd_byte = w_rd_word[15:8];
            2'b10:   w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
    end

    assign w_rd_half = addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        w_load_val = w_rd_word;
        case (size)
            2'b00:   w_load_val = uext ? {24'h0, w_rd_byte}
                                       : {{24{w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_load_val = uext ? {16'h0, w_rd_half}
                                       : {{16{w_rd_half[15]}}, w_rd_half};
            default: w_load_val = w_rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_acc & ~we;
            if (w_acc && !we) begin
                r_rdata <= w_misalign ? 32'h0 : w_load_val;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

`ifdef DM_MISALIGN_CHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_acc & w_misalign;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_sized.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_sized
// Purpose  : Self-checking bench for dm_sized. A byte-array reference model
//            predicts rdata/rvalid/err/busy every cycle; directed literal
//            checks pin the model, randomized traffic exercises the rest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_sized;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << (ADDR_W - 2);
    localparam int NBYTES = 1 << ADDR_W;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              req   = 1'b0;
    logic              we    = 1'b0;
    logic [1:0]        size  = 2'b00;
    logic              uext  = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              busy;
    logic              err;

    dm_sized #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .size   (size),
        .uext   (uext),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: memory as a flat byte array
    // ------------------------------------------------------------------
    logic [7:0]  m_mem [NBYTES];
    int          m_wait  = 0;
    bit          m_ready = 1'b0;
    logic [31:0] e_rdata;
    logic        e_rvalid, e_err, e_busy;

    function automatic bit m_mis(logic [1:0] s, int a);
`ifdef DM_MISALIGN_CHK_EN
        return (s == 2'b01 && (a % 2) != 0) || (s == 2'b10 && (a % 4) != 0) || (s == 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] s, logic u, int a);
        int b;
        logic [31:0] v;
        case (s)
            2'b00: begin
                v = {24'h0, m_mem[a]};
                if (!u && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                b = a - (a % 2);
                v = {16'h0, m_mem[b+1], m_mem[b]};
                if (!u && v[15]) v = v | 32'hFFFF_0000;
            end
            default: begin
                b = a - (a % 4);
                v = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
            end
        endcase
        return v;
    endfunction

    function automatic void m_store(logic [1:0] s, int a, logic [31:0] d);
        int b;
        case (s)
            2'b00: m_mem[a] = d[7:0];
            2'b01: begin
                b = a - (a % 2);
                m_mem[b]   = d[7:0];
                m_mem[b+1] = d[15:8];
            end
            default: begin
                b = a - (a % 4);
                for (int i = 0; i < 4; i++) m_mem[b+i] = d[8*i +: 8];
            end
        endcase
    endfunction

    always @(posedge clk) begin
        int a;
        bit mis;
        a = int'(addr);
        if (rst) begin
            m_wait   = DEPTH;
            e_rdata  = 32'h0;
            e_rvalid = 1'b0;
            e_err    = 1'b0;
            for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
            m_ready  = 1'b1;
        end else if (m_wait > 0) begin
            m_wait   = m_wait - 1;
            e_rvalid = 1'b0;
            e_err    = 1'b0;
        end else begin
            e_rvalid = 1'b0;
            e_err    = 1'b0;
            if (req) begin
                mis   = m_mis(size, a);
                e_err = mis;
                if (we) begin
                    if (!mis) m_store(size, a, wdata);
                end else begin
                    e_rvalid = 1'b1;
                    e_rdata  = mis ? 32'h0 : m_load(size, uext, a);
                end
            end
        end
        e_busy = (m_wait > 0);
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("rvalid", rvalid, e_rvalid);
            chk("rdata",  rdata,  e_rdata);
            chk("err",    err,    e_err);
            chk("busy",   busy,   e_busy);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------
    task automatic op(input logic w, input logic [1:0] s, input logic u,
                      input int a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        size  = s;
        uext  = u;
        addr  = ADDR_W'(a);
        wdata = d;
        @(negedge clk);
        req   = 1'b0;
    endtask

    task automatic drive_rand();
        req   = ($urandom_range(0, 3) != 0);
        we    = $urandom_range(0, 1);
        size  = 2'($urandom_range(0, 3));
        uext  = $urandom_range(0, 1);
        addr  = ADDR_W'($urandom_range(0, 127));
        wdata = $urandom;
    endtask

    // Entered right after a reset edge; releases rst and counts busy cycles
    // while throwing random (ignored) requests at the DUT.
    task automatic busy_wait(output int n, output int rv);
        rst = 1'b0;
        n   = 0;
        rv  = 0;
        while (busy && n < 3000) begin
            n++;
            drive_rand();
            if (n == 1) begin
                req  = 1'b1;
                we   = 1'b0;
                size = 2'b10;
                addr = ADDR_W'(12'h3FC);
            end
            @(negedge clk);
            if (rvalid) rv++;
        end
        req = 1'b0;
    endtask

    initial begin
        int n, rv;

        rst = 1'b1;
        @(negedge clk);
        chk("rst_rdata",  rdata,  32'h0);
        chk("rst_rvalid", rvalid, 32'h0);
        chk("rst_err",    err,    32'h0);
        chk("rst_busy",   busy,   32'h1);
        @(negedge clk);

        busy_wait(n, rv);
        chk("busy_cycles",    n,  32'd1024);
        chk("rvalid_in_busy", rv, 32'd0);

        op(0, 2'b10, 0, 'h3FC, 0);
        chk("ld_3fc_valid", rvalid, 32'h1);
        chk("ld_3fc",       rdata,  32'h0);

        op(1, 2'b10, 0, 'h10, 32'h1122_3344);
        op(1, 2'b00, 0, 'h12, 32'h0000_00AA);
        op(0, 2'b10, 0, 'h10, 0);
        chk("ld_w10", rdata, 32'h11AA_3344);
        op(0, 2'b00, 0, 'h12, 0);
        chk("ld_b12_s", rdata, 32'hFFFF_FFAA);
        op(0, 2'b00, 1, 'h12, 0);
        chk("ld_b12_u", rdata, 32'h0000_00AA);

        op(1, 2'b01, 0, 'h22, 32'h0000_8001);
        op(0, 2'b01, 0, 'h22, 0);
        chk("ld_h22_s", rdata, 32'hFFFF_8001);
        op(0, 2'b10, 0, 'h20, 0);
        chk("ld_w20", rdata, 32'h8001_0000);

        op(0, 2'b10, 0, 'h10, 0);
        chk("b2b_v0", rvalid, 32'h1);
        chk("b2b_d0", rdata,  32'h11AA_3344);
        op(0, 2'b10, 0, 'h20, 0);
        chk("b2b_v1", rvalid, 32'h1);
        chk("b2b_d1", rdata,  32'h8001_0000);

        op(1, 2'b10, 0, 'h10, 32'h5A5A_5A5A);
        op(0, 2'b10, 0, 'h10, 0);
        chk("raw_w10", rdata, 32'h5A5A_5A5A);

        op(1, 2'b10, 0, 'h40, 32'h0102_0304);
        chk("st_no_rvalid", rvalid, 32'h0);
        chk("st_hold",      rdata,  32'h5A5A_5A5A);

        op(1, 2'b10, 0, 'h11, 32'hCAFE_F00D);
`ifdef DM_MISALIGN_CHK_EN
        chk("mis_st_err", err, 32'h1);
        op(0, 2'b10, 0, 'h10, 0);
        chk("mis_st_w10", rdata, 32'h5A5A_5A5A);
        op(0, 2'b01, 0, 'h23, 0);
        chk("mis_ld_err",   err,    32'h1);
        chk("mis_ld_valid", rvalid, 32'h1);
        chk("mis_ld_data",  rdata,  32'h0);
`else
        chk("mis_st_err", err, 32'h0);
        op(0, 2'b10, 0, 'h10, 0);
        chk("mis_st_w10", rdata, 32'hCAFE_F00D);
        op(0, 2'b01, 0, 'h23, 0);
        chk("mis_ld_data", rdata, 32'hFFFF_8001);
`endif

        repeat (3000) begin
            drive_rand();
            @(negedge clk);
        end
        req = 1'b0;
        @(negedge clk);

        op(1, 2'b10, 0, 'h30, 32'hDEAD_BEEF);
        op(0, 2'b10, 0, 'h30, 0);
        chk("pre_rst_w30", rdata, 32'hDEAD_BEEF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        busy_wait(n, rv);
        chk("busy_cycles2",    n,  32'd1024);
        chk("rvalid_in_busy2", rv, 32'd0);
        op(0, 2'b10, 0, 'h30, 0);
        chk("post_rst_w30", rdata, 32'h0);
        op(0, 2'b10, 0, 'h10, 0);
        chk("post_rst_w10", rdata, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
